// File: rtl/z80_bus_pkg.sv
// rtl/z80_bus_pkg.sv - shared types and target indices for the write demux
package z80_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int NUM_TGT = 4;
    localparam int SEL_W   = 2;

    localparam logic [SEL_W-1:0] TGT_MEM = 2'd0;
    localparam logic [SEL_W-1:0] TGT_IO  = 2'd1;
    localparam logic [SEL_W-1:0] TGT_VID = 2'd2;
    localparam logic [SEL_W-1:0] TGT_SND = 2'd3;

endpackage

// File: rtl/timeout_counter.sv
// rtl/timeout_counter.sv - saturating wait counter, expire on the last allowed cycle
module timeout_counter #(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    generate
        if (MAX == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(MAX + 1);
            localparam logic [CW-1:0] LAST = CW'(MAX - 1);
            localparam logic [CW-1:0] TOP  = CW'(MAX);

            logic [CW-1:0] count_q;
            logic [CW-1:0] count_d;

            // clear has priority; otherwise count waiting cycles, sticking at TOP
            always_comb begin
                count_d = count_q;
                if (clr) begin
                    count_d = '0;
                end else if (en && (count_q != TOP)) begin
                    count_d = count_q + 1'b1;
                end
            end

            // count register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign expire = en && (count_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/demux4_wr.sv
// rtl/demux4_wr.sv - registered 1-to-4 write demux with timeout; DEMUX4_WR_PIPE_EN enables back-to-back capture
module demux4_wr
    import z80_bus_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [NUM_TGT-1:0] out_valid,
    input  logic [NUM_TGT-1:0] out_ready,
    output logic               busy,
    output logic               err
);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               err_q, err_d;

    logic               accept;
    logic               capture;
    logic               expire;
    logic [NUM_TGT-1:0] sel_onehot;

    assign busy       = (state_q == HOLD);
    assign sel_onehot = {{(NUM_TGT-1){1'b0}}, 1'b1} << sel_q;
    // out_valid is decoded from state so an async reset drops it immediately
    assign out_valid  = busy ? sel_onehot : '0;
    assign out_data   = data_q;
    assign err        = err_q;
    assign accept     = busy && out_ready[sel_q];
    assign capture    = in_valid && in_ready;

    // in_ready depends only on state (and, when pipelined, on the pending accept)
    always_comb begin
        in_ready = 1'b0;
        if (state_q == IDLE) begin
            in_ready = 1'b1;
        end else begin
`ifdef DEMUX4_WR_PIPE_EN
            in_ready = out_ready[sel_q];
`else
            in_ready = 1'b0;
`endif
        end
    end

    // next-state: capture, accept, or timeout drop; acceptance beats timeout
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        err_d   = 1'b0;
        if (capture) begin
            sel_d  = in_sel;
            data_d = in_data;
        end
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    state_d = capture ? HOLD : IDLE;
                end else if (expire) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and holding registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    timeout_counter #(
        .MAX (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (capture || !busy),
        .en     (busy && !accept),
        .expire (expire)
    );

endmodule

// File: tb/tb_demux4_wr.sv
// tb/tb_demux4_wr.sv - directed vector bench for demux4_wr
module tb_demux4_wr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] in_sel;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic       busy;
    logic       err;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    demux4_wr #(
        .WIDTH   (8),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err)
    );

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
        logic       vld;
        logic [3:0] rdy;
        logic [3:0] e_ov;
        logic [7:0] e_od;
        logic       e_ir;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ws [3];
        logic [7:0] wd [3];
        int         wpos;
        int         cyc;
        bit         done;
        bit         cap;
        logic [1:0] e_sel;
        logic [7:0] e_dat;
        logic [3:0] oh;

        // sel, data, valid, ready -> out_valid, out_data, in_ready, busy, err
        vecs[0]  = '{2'd2, 8'hA5, 1'b1, 4'b0000, 4'b0100, 8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{2'd0, 8'h00, 1'b0, 4'b0100, 4'b0000, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{2'd1, 8'h3C, 1'b1, 4'b1101, 4'b0010, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{2'd0, 8'h00, 1'b0, 4'b1101, 4'b0010, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{2'd3, 8'hFF, 1'b1, 4'b1101, 4'b0010, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{2'd0, 8'h00, 1'b0, 4'b1101, 4'b0010, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{2'd0, 8'h00, 1'b0, 4'b1101, 4'b0010, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{2'd0, 8'h00, 1'b0, 4'b0010, 4'b0000, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{2'd0, 8'h5A, 1'b1, 4'b0000, 4'b0001, 8'h5A, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{2'd0, 8'h00, 1'b0, 4'b1110, 4'b0001, 8'h5A, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{2'd0, 8'h00, 1'b0, 4'b0001, 4'b0000, 8'h5A, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{2'd3, 8'hC3, 1'b1, 4'b0000, 4'b1000, 8'hC3, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{2'd0, 8'h00, 1'b0, 4'b1000, 4'b0000, 8'hC3, 1'b1, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_sel    = 2'd0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 4'b0000;

        // reset values
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_err",       32'(err),       32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        tick();

        // table: basic write, wrong-target ready, other targets
        for (int i = 0; i < 13; i++) begin
            in_sel    = vecs[i].sel;
            in_data   = vecs[i].data;
            in_valid  = vecs[i].vld;
            out_ready = vecs[i].rdy;
            tick();
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d_out_data", i),  32'(out_data),  32'(vecs[i].e_od));
            chk($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
            chk($sformatf("v%0d_busy", i),      32'(busy),      32'(vecs[i].e_busy));
            chk($sformatf("v%0d_err", i),       32'(err),       32'(vecs[i].e_err));
        end
        in_valid  = 1'b0;
        out_ready = 4'b0000;

        // timeout: 15 HOLD cycles, then a single err pulse
        in_sel = 2'd3; in_data = 8'h77; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 15; c++) begin
            chk($sformatf("to_hold%0d_ov", c), 32'(out_valid), 32'h8);
            chk($sformatf("to_hold%0d_err", c), 32'(err), 32'h0);
            if (c < 14) tick();
        end
        tick();
        chk("to_err",      32'(err),       32'h1);
        chk("to_ov",       32'(out_valid), 32'h0);
        chk("to_in_ready", 32'(in_ready),  32'h1);
        chk("to_busy",     32'(busy),      32'h0);
        tick();
        chk("to_err_clear", 32'(err), 32'h0);

        // accept on the expiry edge wins
        in_sel = 2'd3; in_data = 8'h99; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 14; c++) tick();
        chk("tie_still_hold", 32'(out_valid), 32'h8);
        out_ready = 4'b1000;
        tick();
        chk("tie_ov",   32'(out_valid), 32'h0);
        chk("tie_err",  32'(err),       32'h0);
        chk("tie_busy", 32'(busy),      32'h0);
        out_ready = 4'b0000;
        tick();
        chk("tie_err_after", 32'(err), 32'h0);

        // async reset in the middle of HOLD
        in_sel = 2'd2; in_data = 8'h42; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ar_hold", 32'(out_valid), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ov",   32'(out_valid), 32'h0);
        chk("ar_busy", 32'(busy),      32'h0);
        chk("ar_err",  32'(err),       32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ar_in_ready", 32'(in_ready), 32'h1);
        tick();
        chk("ar_err_after", 32'(err), 32'h0);

        // three writes, targets always ready, initiator respects in_ready
        ws[0] = 2'd0; wd[0] = 8'h11;
        ws[1] = 2'd1; wd[1] = 8'h22;
        ws[2] = 2'd2; wd[2] = 8'h33;
        out_ready = 4'b1111;
        wpos = 0; cyc = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (wpos < 3) begin
                in_valid = 1'b1; in_sel = ws[wpos]; in_data = wd[wpos];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            cap = in_valid && in_ready;
            tick();
            cyc++;
            if (cap) begin
                e_sel = ws[wpos];
                e_dat = wd[wpos];
                wpos++;
                oh = 4'b0001 << e_sel;
                chk($sformatf("bb_w%0d_ov", wpos), 32'(out_valid), 32'(oh));
                chk($sformatf("bb_w%0d_od", wpos), 32'(out_data),  32'(e_dat));
            end
            if (wpos == 3 && !busy) done = 1'b1;
        end
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        chk("bb_done", 32'(done), 32'h1);
`ifdef DEMUX4_WR_PIPE_EN
        chk("bb_cycles", 32'(cyc), 32'd4);
`else
        chk("bb_cycles", 32'(cyc), 32'd6);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
